// File: rtl/gb_apu_pkg.sv
// Shared constants and types for the Game Boy APU channel register front ends.
package gb_apu_pkg;

  localparam logic [7:0] ADDR_NR21 = 8'h16;
  localparam logic [7:0] ADDR_NR22 = 8'h17;
  localparam logic [7:0] ADDR_NR23 = 8'h18;
  localparam logic [7:0] ADDR_NR24 = 8'h19;

  // Write-only bits read back as 1
  localparam logic [7:0] RD_MASK_NR21 = 8'h3F;
  localparam logic [7:0] RD_MASK_NR23 = 8'hFF;
  localparam logic [7:0] RD_MASK_NR24 = 8'hBF;
  localparam logic [7:0] RD_MASK_NONE = 8'hFF;

  typedef enum logic {
    TRIG_IDLE  = 1'b0,
    TRIG_PULSE = 1'b1
  } trig_state_t;

endpackage

// File: rtl/apu_trigger_pulse.sv
// Stretches a one-cycle trigger request into a TRIG_CYCLES-long pulse; a new
// request during the pulse restarts the count without a gap.
module apu_trigger_pulse
  import gb_apu_pkg::*;
#(
  parameter int TRIG_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        start,
  output trig_state_t state_o
);

  localparam int CNT_W = $clog2(TRIG_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  trig_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = TRIG_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        TRIG_IDLE: begin
          if (start) begin
            state_d = TRIG_PULSE;
            cnt_d   = CNT_LOAD;
          end
        end
        TRIG_PULSE: begin
          if (start) begin
            cnt_d = CNT_LOAD;
          end else if (cnt_q == '0) begin
            state_d = TRIG_IDLE;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_d = TRIG_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= TRIG_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/pulse_channel2_regs.sv
// NR21..NR24 register front end for pulse channel 2: bus decode, register
// storage, masked read-back and the trigger pulse towards the channel.
module pulse_channel2_regs
  import gb_apu_pkg::*;
#(
  parameter int TRIG_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cs,
  input  logic [7:0]  addr,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [7:0]  wdata,
  output logic [7:0]  rdata,
  output logic        rdata_valid,
  input  logic        apu_power,
  output logic [10:0] freq,
  output logic [5:0]  length_load,
  output logic [1:0]  duty_cycle,
  output logic [3:0]  starting_volume,
  output logic        env_add,
  output logic [2:0]  period,
  output logic        length_enable,
  output logic        trigger,
  output logic        dac_enable
);

  logic [1:0]  duty_q, duty_d;
  logic [5:0]  len_q, len_d;
  logic [7:0]  nr22_q, nr22_d;
  logic [10:0] freq_q, freq_d;
  logic        len_en_q, len_en_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rdata_valid_q, rdata_valid_d;

  logic        wr_hit, rd_hit, trig_start;
  trig_state_t trig_state;

  assign wr_hit     = cs & wr_en & apu_power;
  assign rd_hit     = cs & rd_en;
  assign trig_start = wr_hit & (addr == ADDR_NR24) & wdata[7];

  always_comb begin
    duty_d   = duty_q;
    len_d    = len_q;
    nr22_d   = nr22_q;
    freq_d   = freq_q;
    len_en_d = len_en_q;
    if (!apu_power) begin
      duty_d   = '0;
      len_d    = '0;
      nr22_d   = '0;
      freq_d   = '0;
      len_en_d = 1'b0;
    end else if (wr_hit) begin
      case (addr)
        ADDR_NR21: begin
          duty_d = wdata[7:6];
          len_d  = wdata[5:0];
        end
        ADDR_NR22: nr22_d = wdata;
        ADDR_NR23: freq_d[7:0] = wdata;
        ADDR_NR24: begin
          len_en_d     = wdata[6];
          freq_d[10:8] = wdata[2:0];
        end
        default: ;
      endcase
    end
  end

  // Read mux uses pre-write register values; with power off the fields read as cleared.
  always_comb begin
    rdata_d       = rdata_q;
    rdata_valid_d = rd_hit;
    if (rd_hit) begin
      case (addr)
        ADDR_NR21: rdata_d = {(apu_power ? duty_q : 2'b00), 6'h00} | RD_MASK_NR21;
        ADDR_NR22: rdata_d = apu_power ? nr22_q : 8'h00;
        ADDR_NR23: rdata_d = RD_MASK_NR23;
        ADDR_NR24: rdata_d = {1'b0, (apu_power & len_en_q), 6'h00} | RD_MASK_NR24;
        default:   rdata_d = RD_MASK_NONE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty_q        <= '0;
      len_q         <= '0;
      nr22_q        <= '0;
      freq_q        <= '0;
      len_en_q      <= 1'b0;
      rdata_q       <= '0;
      rdata_valid_q <= 1'b0;
    end else begin
      duty_q        <= duty_d;
      len_q         <= len_d;
      nr22_q        <= nr22_d;
      freq_q        <= freq_d;
      len_en_q      <= len_en_d;
      rdata_q       <= rdata_d;
      rdata_valid_q <= rdata_valid_d;
    end
  end

  apu_trigger_pulse #(
    .TRIG_CYCLES(TRIG_CYCLES)
  ) u_trig (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (~apu_power),
    .start  (trig_start),
    .state_o(trig_state)
  );

  assign trigger         = (trig_state == TRIG_PULSE);
  assign rdata           = rdata_q;
  assign rdata_valid     = rdata_valid_q;
  assign freq            = freq_q;
  assign length_load     = len_q;
  assign duty_cycle      = duty_q;
  assign starting_volume = nr22_q[7:4];
  assign env_add         = nr22_q[3];
  assign period          = nr22_q[2:0];
  assign length_enable   = len_en_q;
  assign dac_enable      = |nr22_q[7:3];

endmodule

// File: tb/tb_pulse_channel2_regs.sv
// Directed bench for pulse_channel2_regs with hand-computed expectations.
module tb_pulse_channel2_regs;

  logic        clk;
  logic        rst_n;
  logic        cs;
  logic [7:0]  addr;
  logic        wr_en;
  logic        rd_en;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        rdata_valid;
  logic        apu_power;
  logic [10:0] freq;
  logic [5:0]  length_load;
  logic [1:0]  duty_cycle;
  logic [3:0]  starting_volume;
  logic        env_add;
  logic [2:0]  period;
  logic        length_enable;
  logic        trigger;
  logic        dac_enable;

  int n_asserts = 0;
  int n_fail    = 0;

  pulse_channel2_regs #(.TRIG_CYCLES(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cs             (cs),
    .addr           (addr),
    .wr_en          (wr_en),
    .rd_en          (rd_en),
    .wdata          (wdata),
    .rdata          (rdata),
    .rdata_valid    (rdata_valid),
    .apu_power      (apu_power),
    .freq           (freq),
    .length_load    (length_load),
    .duty_cycle     (duty_cycle),
    .starting_volume(starting_volume),
    .env_add        (env_add),
    .period         (period),
    .length_enable  (length_enable),
    .trigger        (trigger),
    .dac_enable     (dac_enable)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks: each occupies exactly one active edge
  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    cs = 1'b1; wr_en = 1'b1; addr = a; wdata = d;
    tick();
    cs = 1'b0; wr_en = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a);
    cs = 1'b1; rd_en = 1'b1; addr = a;
    tick();
    cs = 1'b0; rd_en = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [7:0] a, input logic [7:0] exp);
    do_read(a);
    chk({tag, "_data"}, rdata, exp);
    chk({tag, "_valid"}, rdata_valid, 1'b1);
    tick();
    chk({tag, "_valid_drop"}, rdata_valid, 1'b0);
    chk({tag, "_hold"}, rdata, exp);
  endtask

  initial begin
    int highs;
    rst_n = 1'b0; cs = 1'b0; addr = 8'h00; wr_en = 1'b0; rd_en = 1'b0;
    wdata = 8'h00; apu_power = 1'b1;
    tick(); tick();

    // reset state
    chk("rst_freq", freq, 11'd0);
    chk("rst_len", length_load, 6'd0);
    chk("rst_duty", duty_cycle, 2'd0);
    chk("rst_nr22", {starting_volume, env_add, period}, 8'h00);
    chk("rst_len_en", length_enable, 1'b0);
    chk("rst_trigger", trigger, 1'b0);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_rvalid", rdata_valid, 1'b0);
    chk("rst_dac", dac_enable, 1'b0);
    rst_n = 1'b1;
    tick();

    // basic programming sequence
    do_write(8'h16, 8'h52);
    chk("nr21_duty", duty_cycle, 2'b01);
    chk("nr21_len", length_load, 6'h12);
    do_write(8'h17, 8'hF2);
    chk("nr22_vol", starting_volume, 4'hF);
    chk("nr22_env", env_add, 1'b0);
    chk("nr22_period", period, 3'b010);
    chk("nr22_dac", dac_enable, 1'b1);
    do_write(8'h18, 8'h00);
    chk("nr23_trig_idle", trigger, 1'b0);
    do_write(8'h19, 8'hC4);
    chk("nr24_freq", freq, 11'd1024);
    chk("nr24_len_en", length_enable, 1'b1);
    chk("trig_c1", trigger, 1'b1);
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk("trig_hold", trigger, 1'b1);
    end
    tick();
    chk("trig_end", trigger, 1'b0);

    // masked read-back
    read_check("rd16", 8'h16, 8'h7F);
    read_check("rd17", 8'h17, 8'hF2);
    read_check("rd18", 8'h18, 8'hFF);
    read_check("rd19", 8'h19, 8'hFF);

    // retrigger two cycles after the first trigger: 6 contiguous high cycles
    do_write(8'h19, 8'hC4);
    highs = (trigger === 1'b1) ? 1 : 0;
    tick();
    if (trigger === 1'b1) highs++;
    do_write(8'h19, 8'hC4);
    chk("retrig_no_gap", trigger, 1'b1);
    highs++;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (trigger === 1'b1) highs++;
    end
    chk("retrig_len", highs[15:0], 16'd6);
    chk("retrig_end", trigger, 1'b0);

    // power off mid-pulse
    do_write(8'h19, 8'h80);
    tick();
    chk("pwr_pre_trig", trigger, 1'b1);
    apu_power = 1'b0;
    tick();
    chk("pwr_trig", trigger, 1'b0);
    chk("pwr_freq", freq, 11'd0);
    chk("pwr_duty_len", {duty_cycle, length_load}, 8'h00);
    chk("pwr_nr22", {starting_volume, env_add, period}, 8'h00);
    do_write(8'h17, 8'hF0);
    chk("pwr_wr_ignored", starting_volume, 4'h0);
    chk("pwr_dac", dac_enable, 1'b0);
    read_check("pwr_rd16", 8'h16, 8'h3F);
    apu_power = 1'b1;
    tick();

    // DAC off with non-zero period, NR24 write without trigger
    do_write(8'h17, 8'h07);
    chk("dac_off", dac_enable, 1'b0);
    chk("period7", period, 3'b111);
    read_check("rd17b", 8'h17, 8'h07);
    do_write(8'h19, 8'h40);
    chk("nr24_nt_len_en", length_enable, 1'b1);
    chk("nr24_nt_trig", trigger, 1'b0);
    highs = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (trigger === 1'b1) highs++;
    end
    chk("nr24_nt_none", highs[15:0], 16'd0);

    // ignored accesses: cs low, unmapped address
    wr_en = 1'b1; addr = 8'h17; wdata = 8'hF0;
    tick();
    wr_en = 1'b0;
    chk("cs0_wr", starting_volume, 4'h0);
    rd_en = 1'b1; addr = 8'h16;
    tick();
    rd_en = 1'b0;
    chk("cs0_rd", rdata_valid, 1'b0);
    do_write(8'h20, 8'hFF);
    chk("unmapped_wr", {starting_volume, env_add, period}, 8'h07);
    read_check("rd_unmapped", 8'h20, 8'hFF);

    // simultaneous read and write of NR22 returns the pre-write value
    cs = 1'b1; wr_en = 1'b1; rd_en = 1'b1; addr = 8'h17; wdata = 8'hF2;
    tick();
    cs = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    chk("rw_rdata", rdata, 8'h07);
    chk("rw_valid", rdata_valid, 1'b1);
    chk("rw_vol", starting_volume, 4'hF);
    chk("rw_dac", dac_enable, 1'b1);

    // reset during a pulse
    do_write(8'h19, 8'hC4);
    tick();
    chk("rstp_pre", trigger, 1'b1);
    rst_n = 1'b0;
    tick();
    chk("rstp_trig", trigger, 1'b0);
    chk("rstp_freq", freq, 11'd0);
    rst_n = 1'b1;
    highs = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (trigger === 1'b1) highs++;
    end
    chk("rstp_residual", highs[15:0], 16'd0);
    do_write(8'h19, 8'h80);
    chk("rstp_retrigger", trigger, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
